// File: rtl/axi_rd_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_responder_pkg
// Description : Shared encodings for the AXI read responder: burst types,
//               response codes and the responder state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package axi_rd_responder_pkg;

  // AXI burst type encodings (2'b11 is reserved and answered with SLVERR)
  localparam logic [1:0] c_burst_fixed = 2'b00;
  localparam logic [1:0] c_burst_incr  = 2'b01;
  localparam logic [1:0] c_burst_wrap  = 2'b10;

  // AXI response encodings used by this responder
  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  // Responder state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

endpackage : axi_rd_responder_pkg
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr
// Description : Combinational next-word-index calculator for AXI bursts.
//               FIXED holds the index, INCR adds one (mod array size), WRAP
//               increments the low log2(len+1) bits and holds the rest.
// Ports       : idx      in  ADDR_W  current word index
//               burst    in  2       AXI burst type
//               len      in  8       AXI beats-1
//               next_idx out ADDR_W  word index for the following beat
//               illegal  out 1       burst/len combination is not serviceable
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr
  import axi_rd_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] idx,
  input  logic [1:0]        burst,
  input  logic [7:0]        len,
  output logic [ADDR_W-1:0] next_idx,
  output logic              illegal
);

  logic              w_wrap_len_ok;
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_wrap_mask;

  // Only wrap lengths of 2, 4, 8 and 16 beats are legal.
  assign w_wrap_len_ok = (len == 8'd1) || (len == 8'd3) ||
                         (len == 8'd7) || (len == 8'd15);
  assign w_inc         = idx + ADDR_W'(1);
  // For legal wrap lengths len itself is the mask of the wrapping bits.
  assign w_wrap_mask   = ADDR_W'(len[3:0]);

  always_comb begin
    next_idx = w_inc;
    illegal  = 1'b0;
    case (burst)
      c_burst_fixed: next_idx = idx;
      c_burst_incr:  next_idx = w_inc;
      c_burst_wrap: begin
        next_idx = (idx & ~w_wrap_mask) | (w_inc & w_wrap_mask);
        illegal  = ~w_wrap_len_ok;
      end
      default:       illegal  = 1'b1;
    endcase
  end

endmodule : axi_burst_addr
`default_nettype wire

// File: rtl/axi_rd_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_responder
// Description : Single-outstanding AXI read responder backed by an inferred
//               32-bit word array with a backdoor load port.
// Ports       : clk, rst (sync, active-low)
//               araddr/arlen/arburst/arvalid/arready : AR channel
//               rdata/rresp/rlast/rvalid/rready      : R channel
//               init_we/init_addr/init_wdata         : backdoor array write
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_responder
  import axi_rd_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1fc0_0000,
  parameter int unsigned LATENCY   = 2,
  localparam int unsigned ADDR_W   = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [31:0]       init_wdata
);

  localparam int unsigned c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]        r_mem [MEM_WORDS];

  logic [ADDR_W-1:0]  r_idx;
  logic [1:0]         r_burst;
  logic [7:0]         r_len;
  logic               r_range_err;
  logic [7:0]         r_beat;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_rdata;
  logic [1:0]         r_rresp;
  logic               r_rlast;

  logic               w_ar_hs;
  logic               w_load_first;
  logic               w_load_next;
  logic               w_done;
  logic [ADDR_W-1:0]  w_idx_next;
  logic               w_illegal;
  logic               w_slverr;
  logic [ADDR_W-1:0]  w_load_idx;
  logic [7:0]         w_beat_load;
  logic               w_unused;

  // Byte-lane bits of the address carry no meaning for a word array.
  assign w_unused = ^araddr[1:0];

  assign arready = (r_state == IDLE);
  // A beat is always loaded on entry to BURST, so rvalid tracks the state.
  assign rvalid  = (r_state == BURST);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;

  axi_burst_addr #(
    .ADDR_W   (ADDR_W)
  ) u_burst_addr (
    .idx      (r_idx),
    .burst    (r_burst),
    .len      (r_len),
    .next_idx (w_idx_next),
    .illegal  (w_illegal)
  );

  assign w_slverr    = r_range_err | w_illegal;
  assign w_load_idx  = w_load_next ? w_idx_next : r_idx;
  assign w_beat_load = w_load_next ? (r_beat + 8'd1) : 8'd0;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ar_hs      = 1'b0;
    w_load_first = 1'b0;
    w_load_next  = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (arvalid) begin
          w_ar_hs      = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_load_first = 1'b1;
          w_state_next = BURST;
        end
      end
      BURST: begin
        if (rready) begin
          if (r_rlast) begin
            w_done       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_load_next  = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction context and beat registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx       <= '0;
      r_burst     <= c_burst_fixed;
      r_len       <= '0;
      r_range_err <= 1'b0;
      r_beat      <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_rresp     <= c_resp_okay;
      r_rlast     <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_idx       <= araddr[ADDR_W+1:2];
        r_burst     <= arburst;
        r_len       <= arlen;
        r_range_err <= (araddr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
        r_cnt       <= c_CNT_W'(LATENCY - 1);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt       <= r_cnt - c_CNT_W'(1);
      end

      if (w_load_first || w_load_next) begin
        // Array read uses the pre-write contents when init_we hits the
        // same word on this edge.
        r_rdata <= w_slverr ? 32'd0 : r_mem[w_load_idx];
        r_rresp <= w_slverr ? c_resp_slverr : c_resp_okay;
        r_rlast <= (w_beat_load == r_len);
        r_beat  <= w_beat_load;
        r_idx   <= w_load_idx;
      end else if (w_done) begin
        r_rlast <= 1'b0;
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (init_we) begin
      r_mem[init_addr] <= init_wdata;
    end
  end

endmodule : axi_rd_responder
`default_nettype wire

// File: tb/tb_axi_rd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_responder
// Description : Directed self-checking bench for axi_rd_responder.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_responder;

  localparam int unsigned c_ADDR_W = 10;

  logic                clk;
  logic                rst;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic                init_we;
  logic [c_ADDR_W-1:0] init_addr;
  logic [31:0]         init_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  axi_rd_responder #(
    .MEM_WORDS  (1024),
    .BASE_ADDR  (32'h1fc0_0000),
    .LATENCY    (2)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .araddr     (araddr),
    .arlen      (arlen),
    .arburst    (arburst),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .rvalid     (rvalid),
    .rready     (rready),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_wdata (init_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    check_eq("arready_idle", {31'd0, arready}, 32'd1);
    araddr  = addr;
    arlen   = len;
    arburst = burst;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
  endtask

  // Waits (bounded) for a beat, checks it, then lets rready=1 consume it.
  task automatic expect_beat(input string tag, input logic [31:0] data,
                             input logic [1:0] resp, input logic last);
    for (int i = 0; i < 20 && !rvalid; i++) tick();
    check_eq({tag, "_valid"}, {31'd0, rvalid}, 32'd1);
    check_eq({tag, "_data"},  rdata, data);
    check_eq({tag, "_resp"},  {30'd0, rresp}, {30'd0, resp});
    check_eq({tag, "_last"},  {31'd0, rlast}, {31'd0, last});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    araddr     = '0;
    arlen      = '0;
    arburst    = '0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    init_we    = 1'b0;
    init_addr  = '0;
    init_wdata = '0;
    tick();
    tick();

    // Reset state
    check_eq("rst_arready", {31'd0, arready}, 32'd1);
    check_eq("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check_eq("rst_rlast",   {31'd0, rlast},   32'd0);
    check_eq("rst_rresp",   {30'd0, rresp},   32'd0);
    check_eq("rst_rdata",   rdata,            32'd0);
    rst = 1'b1;

    // Preload words 0..7 = A0..A7 and word 1023 = FF
    for (int i = 0; i < 8; i++) begin
      init_we    = 1'b1;
      init_addr  = c_ADDR_W'(i);
      init_wdata = 32'hA0 + 32'(i);
      tick();
    end
    init_addr  = 10'd1023;
    init_wdata = 32'hFF;
    tick();
    init_we    = 1'b0;

    // WRAP 4 beats from word 2, with latency check
    rready = 1'b1;
    ar_send(32'h1fc0_0008, 8'd3, 2'b10);
    check_eq("wrap_lat0_rvalid", {31'd0, rvalid},  32'd0);
    check_eq("wrap_lat0_arready", {31'd0, arready}, 32'd0);
    tick();
    check_eq("wrap_lat1_rvalid", {31'd0, rvalid},  32'd0);
    tick();
    check_eq("wrap_lat2_rvalid", {31'd0, rvalid},  32'd1);
    expect_beat("wrap_b0", 32'hA2, 2'b00, 1'b0);
    expect_beat("wrap_b1", 32'hA3, 2'b00, 1'b0);
    expect_beat("wrap_b2", 32'hA0, 2'b00, 1'b0);
    expect_beat("wrap_b3", 32'hA1, 2'b00, 1'b1);
    check_eq("wrap_end_rvalid",  {31'd0, rvalid},  32'd0);
    check_eq("wrap_end_arready", {31'd0, arready}, 32'd1);

    // INCR 2 beats with back-pressure on beat 0
    rready = 1'b0;
    ar_send(32'h1fc0_0004, 8'd1, 2'b01);
    for (int i = 0; i < 20 && !rvalid; i++) tick();
    check_eq("bp_b0_data", rdata, 32'hA1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("bp_hold_valid", {31'd0, rvalid}, 32'd1);
      check_eq("bp_hold_data",  rdata, 32'hA1);
      check_eq("bp_hold_last",  {31'd0, rlast}, 32'd0);
    end
    rready = 1'b1;
    tick();
    check_eq("bp_b1_data", rdata, 32'hA2);
    check_eq("bp_b1_last", {31'd0, rlast}, 32'd1);
    tick();
    check_eq("bp_end_arready", {31'd0, arready}, 32'd1);
    check_eq("bp_end_rvalid",  {31'd0, rvalid},  32'd0);

    // Out-of-range address
    ar_send(32'h0000_1000, 8'd1, 2'b01);
    expect_beat("oor_b0", 32'd0, 2'b10, 1'b0);
    expect_beat("oor_b1", 32'd0, 2'b10, 1'b1);
    check_eq("oor_end_rvalid", {31'd0, rvalid}, 32'd0);

    // WRAP with illegal length, and reserved burst type
    ar_send(32'h1fc0_0000, 8'd2, 2'b10);
    expect_beat("wrapbad_b0", 32'd0, 2'b10, 1'b0);
    expect_beat("wrapbad_b1", 32'd0, 2'b10, 1'b0);
    expect_beat("wrapbad_b2", 32'd0, 2'b10, 1'b1);
    ar_send(32'h1fc0_0000, 8'd0, 2'b11);
    expect_beat("rsvd_b0", 32'd0, 2'b10, 1'b1);

    // INCR across the top of the array wraps to word 0
    ar_send(32'h1fc0_0ffc, 8'd1, 2'b01);
    expect_beat("incrwrap_b0", 32'hFF, 2'b00, 1'b0);
    expect_beat("incrwrap_b1", 32'hA0, 2'b00, 1'b1);

    // Reset mid-burst
    ar_send(32'h1fc0_0000, 8'd7, 2'b01);
    expect_beat("mid_b0", 32'hA0, 2'b00, 1'b0);
    expect_beat("mid_b1", 32'hA1, 2'b00, 1'b0);
    check_eq("mid_b2_data", rdata, 32'hA2);
    rst = 1'b0;
    tick();
    check_eq("mid_rst_rvalid",  {31'd0, rvalid},  32'd0);
    check_eq("mid_rst_arready", {31'd0, arready}, 32'd1);
    check_eq("mid_rst_rlast",   {31'd0, rlast},   32'd0);
    check_eq("mid_rst_rdata",   rdata,            32'd0);
    rst = 1'b1;
    ar_send(32'h1fc0_000c, 8'd1, 2'b01);
    expect_beat("post_b0", 32'hA3, 2'b00, 1'b0);
    expect_beat("post_b1", 32'hA4, 2'b00, 1'b1);

    // Backdoor write colliding with the load of beat 0 of a FIXED burst
    ar_send(32'h1fc0_0014, 8'd2, 2'b00);
    tick();
    init_we    = 1'b1;
    init_addr  = 10'd5;
    init_wdata = 32'h55;
    tick();
    init_we    = 1'b0;
    expect_beat("coll_b0", 32'hA5, 2'b00, 1'b0);
    expect_beat("coll_b1", 32'h55, 2'b00, 1'b0);
    expect_beat("coll_b2", 32'h55, 2'b00, 1'b1);
    check_eq("coll_end_arready", {31'd0, arready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_axi_rd_responder
`default_nettype wire
